// File: rtl/poly_mult_result_reader_if.sv
// rtl/poly_mult_result_reader_if.sv - result-memory read port and output word stream bundle
interface poly_mult_result_reader_if #(
  parameter int RAMWIDTH   = 128,
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic                  rd_dout;
  logic [ADDR_WIDTH-1:0] addr_result;
  logic [RAMWIDTH-1:0]   dout;
  logic [RAMWIDTH-1:0]   out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, dout, out_ready,
    output rd_dout, addr_result, out_data, out_valid, out_last, busy, done
  );

  modport slave (
    output start, dout, out_ready,
    input  rd_dout, addr_result, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/poly_mult_result_reader.sv
// rtl/poly_mult_result_reader.sv - streams the multiplier result memory as valid/ready words
// Optional: RESULT_TAIL_MASK_EN zeroes the unused top bits of the final word.
module poly_mult_result_reader #(
  parameter int N          = 17669,
  parameter int RAMWIDTH   = 128,
  parameter int N_WORDS    = (N + RAMWIDTH - 1) / RAMWIDTH,
  parameter int ADDR_WIDTH = $clog2(N_WORDS)
) (
  input  logic clk,
  input  logic rst,
  poly_mult_result_reader_if.master io_bus
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_WORDS - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_head_idx;
  logic                  r_inflight;
  logic [RAMWIDTH-1:0]   r_buf [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_head_last;
  logic                  w_rd_dout;
  logic                  w_busy;
  logic                  w_done;
  logic [RAMWIDTH-1:0]   w_wr_data;

  assign w_valid     = (r_count != 2'd0);
  assign w_pop       = w_valid && io_bus.out_ready;
  assign w_head_last = (r_head_idx == LAST_ADDR);
  // Credit: buffered + in-flight words minus this cycle's pop must leave room for one more.
  assign w_issue     = (r_state == S_READ) &&
                       ((3'(r_count) + 3'(r_inflight)) < (3'd2 + 3'(w_pop)));

`ifdef RESULT_TAIL_MASK_EN
  localparam int TAIL_BITS = N % RAMWIDTH;
  localparam logic [RAMWIDTH-1:0] TAIL_MASK = (TAIL_BITS == 0) ? {RAMWIDTH{1'b1}}
                                              : ({RAMWIDTH{1'b1}} >> (RAMWIDTH - TAIL_BITS));
  logic r_inflight_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_inflight_last <= 1'b0;
    else     r_inflight_last <= (r_addr == LAST_ADDR);
  end

  assign w_wr_data = r_inflight_last ? (io_bus.dout & TAIL_MASK) : io_bus.dout;
`else
  assign w_wr_data = io_bus.dout;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (io_bus.start) w_next_state = S_READ;
      S_READ:  if (w_issue && (r_addr == LAST_ADDR)) w_next_state = S_DRAIN;
      S_DRAIN: if (w_pop && w_head_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_dout = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_READ, S_DRAIN: begin
        w_rd_dout = 1'b1;
        w_busy    = 1'b1;
      end
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_head_idx <= '0;
      r_inflight <= 1'b0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      if ((r_state == S_IDLE) && io_bus.start) begin
        r_addr     <= '0;
        r_head_idx <= '0;
      end else begin
        if (w_issue && (r_addr != LAST_ADDR)) r_addr <= r_addr + 1'b1;
        if (w_pop) r_head_idx <= r_head_idx + 1'b1;
      end
      // The memory answers one cycle after the address; that word always has a free slot.
      r_inflight <= w_issue;
      if (r_inflight) begin
        r_buf[r_wr_ptr] <= w_wr_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(r_inflight) - 2'(w_pop);
    end
  end

  assign io_bus.rd_dout     = w_rd_dout;
  assign io_bus.busy        = w_busy;
  assign io_bus.done        = w_done;
  assign io_bus.addr_result = r_addr;
  assign io_bus.out_valid   = w_valid;
  assign io_bus.out_data    = w_valid ? r_buf[r_rd_ptr] : '0;
  assign io_bus.out_last    = w_valid && w_head_last;
endmodule

// File: tb/tb_poly_mult_result_reader.sv
// tb/tb_poly_mult_result_reader.sv - scoreboard bench for poly_mult_result_reader
module tb_poly_mult_result_reader;
  localparam int NW = 139;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   beats_seen = 0;
  int   first_beat_cyc = -1;
  int   last_beat_cyc = -1;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   ready_mode = 0;
  int   stall_cnt = 0;
  logic prev_stall = 1'b0;
  logic [127:0] prev_data = '0;
  logic [127:0] mem [0:255];
  exp_t exp_q [$];

  poly_mult_result_reader_if #(.RAMWIDTH(128), .ADDR_WIDTH(8)) bus ();

  poly_mult_result_reader #(.N(17669), .RAMWIDTH(128)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.dout <= mem[bus.addr_result];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_word(input int k, input bit tail);
    logic [7:0] b;
    b = k[7:0];
    if (k == NW - 1) begin
`ifdef RESULT_TAIL_MASK_EN
      return tail ? 128'h1F : 128'h0A;
`else
      return tail ? {128{1'b1}} : {16{8'h8A}};
`endif
    end
    return {16{b}};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 128'(bus.out_valid), 128'd1);
        check("stall_data", bus.out_data, prev_data);
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 128'd1, 128'd0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", bus.out_data, e.data);
          check("beat_last", 128'(bus.out_last), 128'(e.last));
        end
        if (beats_seen == 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        beats_seen++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        bus.out_ready = 1'b1;
      end else if (beats_seen >= 6 && stall_cnt < 10) begin
        bus.out_ready = 1'b0;
        stall_cnt++;
      end else if (stall_cnt >= 10) begin
        bus.out_ready = ~bus.out_ready;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, 128'({bus.rd_dout, bus.addr_result, bus.out_valid,
                               bus.out_last, bus.busy, bus.done}), 128'd0);
    check({tag, "_data"}, bus.out_data, 128'd0);
  endtask

  task automatic load_and_expect(input bit tail);
    for (int k = 0; k < NW; k++) begin
      mem[k] = {16{8'(k)}};
      exp_q.push_back('{data: exp_word(k, tail), last: (k == NW - 1)});
    end
    if (tail) mem[NW-1] = {128{1'b1}};
    beats_seen = 0;
    first_beat_cyc = -1;
    last_beat_cyc = -1;
    stall_cnt = 0;
  endtask

  task automatic run(input int mode, input bit tail, input bit repulse, input bit timing);
    int t0;
    int d0;
    exp_q.delete();
    load_and_expect(tail);
    ready_mode = mode;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("start_busy", 128'(bus.busy), 128'd1);
    check("start_rd_dout", 128'(bus.rd_dout), 128'd1);
    check("start_addr", 128'(bus.addr_result), 128'd0);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
      @(posedge clk);
      #1;
      bus.start = repulse && (cyc == t0 + 20 || cyc == t0 + 140);
    end
    bus.start = 1'b0;
    check("done_pulses", 128'(done_cnt), 128'(d0 + 1));
    check("beat_count", 128'(beats_seen), 128'(NW));
    check("queue_empty", 128'(exp_q.size()), 128'd0);
    if (timing) begin
      check("first_beat_cyc", 128'(first_beat_cyc - t0), 128'd3);
      check("last_beat_cyc", 128'(last_beat_cyc - t0), 128'd141);
      check("done_cyc", 128'(done_cyc - t0), 128'd142);
    end
    repeat (5) @(negedge clk);
    check("single_done", 128'(done_cnt), 128'(d0 + 1));
    check("idle_busy", 128'(bus.busy), 128'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("reset_async");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("idle_after_reset");

    run(0, 1'b0, 1'b0, 1'b1);
    run(1, 1'b0, 1'b0, 1'b0);
    run(0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a run, then restart from address 0.
    exp_q.delete();
    load_and_expect(1'b0);
    ready_mode = 0;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < 500 && beats_seen < 51; i++) @(posedge clk);
    check("midrun_reached", 128'(beats_seen >= 51), 128'd1);
    #3;
    rst = 1'b1;
    #1;
    check_outputs_zero("midrun_reset");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(0, 1'b0, 1'b0, 1'b1);

    run(0, 1'b0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
